// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: inter-stage bus layouts, load-op codes, response FSM.
package mem_stage_pkg;

  // ld_op is one-hot {w, hu, h, bu, b}
  localparam logic [4:0] LD_B  = 5'b00001;
  localparam logic [4:0] LD_BU = 5'b00010;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b01000;
  localparam logic [4:0] LD_W  = 5'b10000;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  tlb_op;
    logic        csr_we;
    logic [13:0] csr_num;
    logic        refetch;
    logic        ertn;
    logic        ex;
    logic [5:0]  ecode;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } wb_fields_t;

  typedef struct packed {
    logic       ms_req;
    logic [4:0] ld_op;
    logic [1:0] vaddr;
    wb_fields_t wb;
  } es_to_ms_t;

  localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
  localparam int MS_TO_WS_BUS_WD = $bits(wb_fields_t);
  localparam int MS_TO_DS_BUS_WD = 1 + 5 + 32 + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } resp_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half/word lane of load data and sign- or zero-extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  ld_op_i,
  input  logic [1:0]  vaddr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (vaddr_i)
      2'b00:   byte_v = rdata_i[7:0];
      2'b01:   byte_v = rdata_i[15:8];
      2'b10:   byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = vaddr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    unique case (ld_op_i)
      LD_B:    result_o = {{24{byte_v[7]}}, byte_v};
      LD_BU:   result_o = {24'b0, byte_v};
      LD_H:    result_o = {{16{half_v[15]}}, half_v};
      LD_HU:   result_o = {16'b0, half_v};
      LD_W:    result_o = rdata_i;
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the in-order data-bus response, buffers it under WB back-pressure,
// and drops responses owed to flushed instructions via a saturating cancel counter.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned CANCEL_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       ws_allowin,
  input  logic                       ws_flush_pipe,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  output logic                       ms_ex_to_es
);

  localparam int CntW = CANCEL_W + 2;
  localparam logic [CANCEL_W-1:0] CancelMax = '1;

  logic          ms_valid_q, ms_valid_d;
  es_to_ms_t     bus_q, es_bus;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic [CntW-1:0]     cnt_sum;
  logic [31:0]   resp_buf_q;
  resp_state_e   state_q, state_d;

  logic ms_req, cancel_busy, cancel_full, own_ok, ms_ready_go, handoff;
  logic resp_buf_v, resp_latch, inc_ms, inc_es, dec;
  logic ms_is_load;
  logic [31:0] ld_data, ld_result, final_result;
  wb_fields_t  ws_fields;

  assign es_bus      = es_to_ms_bus;
  assign ms_req      = bus_q.ms_req;
  assign ms_is_load  = bus_q.ld_op != 5'b0;
  assign cancel_busy = cancel_cnt_q != '0;
  assign cancel_full = cancel_cnt_q == CancelMax;

  // A response is ours only once every cancelled response ahead of it has drained.
  assign own_ok = data_sram_data_ok && !cancel_busy && ms_valid_q && ms_req && !resp_buf_v;

  assign ms_ready_go    = !ms_req || resp_buf_v || (data_sram_data_ok && !cancel_busy);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign ms_allowin     = !cancel_full && (!ms_valid_q || (ms_ready_go && ws_allowin));
  assign handoff        = ms_to_ws_valid && ws_allowin;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (ws_flush_pipe) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
  end

  // Flush orphans the MS request still in flight and any request EX already issued.
  always_comb begin
    inc_ms  = ws_flush_pipe && ms_valid_q && ms_req && !resp_buf_v && !own_ok;
    inc_es  = ws_flush_pipe && es_to_ms_valid && es_bus.ms_req;
    dec     = data_sram_data_ok && cancel_busy;
    cnt_sum = CntW'(cancel_cnt_q) + CntW'(inc_ms) + CntW'(inc_es) - CntW'(dec);
    cancel_cnt_d = (cnt_sum > CntW'(CancelMax)) ? CancelMax : cnt_sum[CANCEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      cancel_cnt_q <= '0;
      resp_buf_q   <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      cancel_cnt_q <= cancel_cnt_d;
      if (es_to_ms_valid && ms_allowin && !ws_flush_pipe) begin
        bus_q <= es_bus;
      end
      if (resp_latch) begin
        resp_buf_q <= data_sram_rdata;
      end
    end
  end

  // Response FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Response FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StWait: begin
        if (ms_valid_q && ms_req) begin
          if (own_ok) begin
            state_d = ws_allowin ? StIdle : StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StDone: begin
        if (handoff) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (ws_flush_pipe) state_d = StIdle;
  end

  // Response FSM: outputs
  always_comb begin
    resp_buf_v = (state_q == StDone);
    resp_latch = own_ok && !ws_allowin && !ws_flush_pipe;
  end

  assign ld_data = resp_buf_v ? resp_buf_q : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .ld_op_i  (bus_q.ld_op),
    .vaddr_i  (bus_q.vaddr),
    .rdata_i  (ld_data),
    .result_o (ld_result)
  );

  assign final_result = ms_is_load ? ld_result : bus_q.wb.result;

  always_comb begin
    ws_fields        = bus_q.wb;
    ws_fields.result = final_result;
  end

  assign ms_to_ws_bus = ws_fields;
  assign ms_to_ds_bus = {ms_valid_q && bus_q.wb.gr_we, bus_q.wb.dest, final_result,
                         ms_valid_q && ms_is_load && !ms_ready_go};
  assign ms_ex_to_es  = ms_valid_q && (bus_q.wb.ex || bus_q.wb.ertn || bus_q.wb.refetch);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected WB buses, a negedge monitor checks them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ms_allowin, es_to_ms_valid, ms_to_ws_valid, ws_allowin, ws_flush_pipe;
  logic data_sram_data_ok, ms_ex_to_es;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;
  logic [31:0] data_sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [MS_TO_WS_BUS_WD-1:0] exp_q[$];
  logic [MS_TO_WS_BUS_WD-1:0] mon_exp;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .ws_flush_pipe     (ws_flush_pipe),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .ms_ex_to_es       (ms_ex_to_es)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic wb_fields_t mk_f(input logic [31:0] pc, input logic [31:0] res,
                                      input logic [4:0] dest);
    wb_fields_t f;
    f        = '0;
    f.pc     = pc;
    f.result = res;
    f.dest   = dest;
    f.gr_we  = 1'b1;
    return f;
  endfunction

  function automatic logic [ES_TO_MS_BUS_WD-1:0] mk_es(input logic req, input logic [4:0] op,
                                                       input logic [1:0] va, input wb_fields_t f);
    es_to_ms_t e;
    e.ms_req = req;
    e.ld_op  = op;
    e.vaddr  = va;
    e.wb     = f;
    return e;
  endfunction

  function automatic logic [MS_TO_WS_BUS_WD-1:0] exp_ws(input wb_fields_t f,
                                                        input logic [31:0] res);
    wb_fields_t w;
    w        = f;
    w.result = res;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the instr on the EX side until MS accepts it; returns just after the capturing edge.
  task automatic send(input logic [ES_TO_MS_BUS_WD-1:0] bus);
    int cyc;
    cyc = 0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    while (!ms_allowin && cyc < 50) begin
      step();
      cyc++;
    end
    check("send_allowin", ms_allowin, 1);
    step();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] op, input logic [1:0] va, input logic [31:0] rd,
                         input logic [31:0] res, input int waits);
    wb_fields_t f;
    f = mk_f(32'h1c00_1000, 32'h0000_0100, 5'd9);
    exp_ws_push(f, res);
    send(mk_es(1'b1, op, va, f));
    for (int i = 0; i < waits; i++) begin
      check("load_wait_valid", ms_to_ws_valid, 0);
      check("load_use_stall", ms_to_ds_bus[0], 1);
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h5555_5555;
  endtask

  task automatic exp_ws_push(input wb_fields_t f, input logic [31:0] res);
    exp_q.push_back(exp_ws(f, res));
  endtask

  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ws_unexpected: got %0h required no output", ms_to_ws_bus);
      end else begin
        mon_exp = exp_q.pop_front();
        check("ws_bus", ms_to_ws_bus, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_fields_t f;
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    ws_flush_pipe = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    step();
    step();
    check("rst_allowin", ms_allowin, 1);
    check("rst_ws_valid", ms_to_ws_valid, 0);
    check("rst_ex_to_es", ms_ex_to_es, 0);
    check("rst_ds_bus", ms_to_ds_bus, 0);
    check("rst_ws_bus", ms_to_ws_bus, 0);
    reset = 1'b0;

    // ALU instr: one-cycle latency, result unchanged
    f = mk_f(32'h1c00_0000, 32'hDEAD_BEEF, 5'd5);
    exp_ws_push(f, 32'hDEAD_BEEF);
    send(mk_es(1'b0, 5'b0, 2'b00, f));
    check("alu_valid", ms_to_ws_valid, 1);
    check("alu_ds_bus", ms_to_ds_bus, {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0});
    step();
    check("alu_gone", ms_to_ws_valid, 0);

    // Load alignment
    do_load(LD_B,  2'b11, 32'h80FF_0000, 32'hFFFF_FF80, 0);
    do_load(LD_BU, 2'b11, 32'h80FF_0000, 32'h0000_0080, 1);
    do_load(LD_H,  2'b10, 32'h80FF_0000, 32'hFFFF_80FF, 2);
    do_load(LD_HU, 2'b00, 32'h1234_8765, 32'h0000_8765, 0);
    do_load(LD_B,  2'b01, 32'h0000_7F00, 32'h0000_007F, 1);
    do_load(LD_W,  2'b00, 32'hCAFE_BABE, 32'hCAFE_BABE, 0);

    // Response arrives while WB stalls: buffered value delivered once
    f = mk_f(32'h1c00_2000, 32'h0, 5'd3);
    exp_ws_push(f, 32'h1234_5678);
    send(mk_es(1'b1, LD_W, 2'b00, f));
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hAAAA_AAAA;
    check("buf_valid", ms_to_ws_valid, 1);
    check("buf_blocks_ex", ms_allowin, 0);
    step();
    step();
    ws_allowin = 1'b1;
    step();
    check("buf_once", ms_to_ws_valid, 0);

    // Flush a waiting load; its late response must not complete the next load
    f = mk_f(32'h1c00_3000, 32'h0, 5'd4);
    send(mk_es(1'b1, LD_W, 2'b00, f));
    step();
    ws_flush_pipe = 1'b1;
    step();
    ws_flush_pipe = 1'b0;
    check("flush_valid", ms_to_ws_valid, 0);
    check("flush_allowin", ms_allowin, 1);
    f = mk_f(32'h1c00_3004, 32'h0, 5'd6);
    exp_ws_push(f, 32'hCAFE_F00D);
    send(mk_es(1'b1, LD_W, 2'b00, f));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_0000;
    check("stale_drop", ms_to_ws_valid, 0);
    step();
    data_sram_rdata = 32'hCAFE_F00D;
    check("own_after_drop", ms_to_ws_valid, 1);
    step();
    data_sram_data_ok = 1'b0;

    // Saturate cancel counter: MS load + EX pending request, then one more flushed load
    f = mk_f(32'h1c00_4000, 32'h0, 5'd1);
    send(mk_es(1'b1, LD_W, 2'b00, f));
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_es(1'b1, LD_W, 2'b00, mk_f(32'h1c00_4004, 32'h0, 5'd2));
    ws_flush_pipe  = 1'b1;
    step();
    ws_flush_pipe  = 1'b0;
    es_to_ms_valid = 1'b0;
    check("cnt2_allowin", ms_allowin, 1);
    send(mk_es(1'b1, LD_W, 2'b00, mk_f(32'h1c00_4008, 32'h0, 5'd3)));
    ws_flush_pipe = 1'b1;
    step();
    ws_flush_pipe = 1'b0;
    check("sat_allowin", ms_allowin, 0);
    f = mk_f(32'h1c00_400c, 32'h0000_0777, 5'd8);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_es(1'b0, 5'b0, 2'b00, f);
    step();
    check("sat_no_admit", ms_to_ws_valid, 0);
    check("sat_still_full", ms_allowin, 0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_0001;
    step();
    data_sram_data_ok = 1'b0;
    check("sat_release", ms_allowin, 1);
    exp_ws_push(f, 32'h0000_0777);
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_0002;
    step();
    data_sram_rdata = 32'hBAD0_0003;
    step();
    data_sram_data_ok = 1'b0;
    do_load(LD_W, 2'b00, 32'h1357_9BDF, 32'h1357_9BDF, 0);

    // Syscall exception held in MS
    f = mk_f(32'h1c00_5000, 32'h0000_0042, 5'd7);
    f.ex    = 1'b1;
    f.ecode = 6'h0B;
    ws_allowin = 1'b0;
    exp_ws_push(f, 32'h0000_0042);
    send(mk_es(1'b0, 5'b0, 2'b00, f));
    check("ex_to_es", ms_ex_to_es, 1);
    check("ex_valid", ms_to_ws_valid, 1);
    check("ex_gr_we", ms_to_ds_bus[38], 1);
    ws_allowin = 1'b1;
    step();
    check("ex_cleared", ms_ex_to_es, 0);

    // Reset while a load waits
    send(mk_es(1'b1, LD_W, 2'b00, mk_f(32'h1c00_6000, 32'h0, 5'd10)));
    step();
    check("wait_stall", ms_to_ds_bus[0], 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_allowin", ms_allowin, 1);
    check("mid_rst_valid", ms_to_ws_valid, 0);
    check("mid_rst_ds_bus", ms_to_ds_bus, 0);
    check("mid_rst_ws_bus", ms_to_ws_bus, 0);
    do_load(LD_W, 2'b00, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1);

    step();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
